// File: rtl/lpc_record_scheduler.sv
// ---------------------------------------------------------------------------
// lpc_record_scheduler
//
// Buffers decoded LPC cycle records in a small FIFO and serialises each one
// as a 10-byte frame on a byte-wide valid/ready stream:
//   header, {ct_dir,size}, addr[31:24..7:0], data[31:24..7:0]
// Records that arrive while the FIFO is full (and no pop frees a slot on the
// same edge) are dropped. Drops are counted (saturating) and flagged in-band:
// the next frame popped afterwards carries HDR_DROP instead of HDR_OK.
//
// Ports
//   lpc_clock        in   clock
//   lpc_reset        in   asynchronous active-high reset
//   in_cyctype_dir   in   [3:0]  decoder cycle type / direction
//   in_addr          in   [31:0] decoder address
//   in_data          in   [31:0] decoder data
//   in_data_size     in   [3:0]  decoder data size
//   in_clock_enable  in   record strobe, fields valid while high
//   out_byte         out  [7:0]  stream byte (registered)
//   out_valid        out  stream valid (registered)
//   out_ready        in   stream ready from the byte sink
//   fifo_level       out  records currently stored
//   overflow_count   out  [15:0] dropped records, saturating
//   busy             out  FIFO non-empty or a frame in flight
// ---------------------------------------------------------------------------
module lpc_record_scheduler #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] HDR_OK     = 8'hA5,
    parameter logic [7:0] HDR_DROP   = 8'hA6
) (
    input  logic                          lpc_clock,
    input  logic                          lpc_reset,
    input  logic [3:0]                    in_cyctype_dir,
    input  logic [31:0]                   in_addr,
    input  logic [31:0]                   in_data,
    input  logic [3:0]                    in_data_size,
    input  logic                          in_clock_enable,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   overflow_count,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Storage and bookkeeping
    logic [71:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic [15:0]   ovf_q;
    logic [15:0]   ovf_d;
    logic          drop_pending_q;
    logic          drop_pending_d;

    // Frame FSM state
    state_t        state_q;
    logic [71:0]   frame_q;
    logic [3:0]    idx_q;
    logic [7:0]    out_byte_q;
    logic          out_valid_q;
    logic          busy_q;

    // Per-edge events
    logic [71:0]   record_s;
    logic          pop_s;
    logic          full_s;
    logic          push_s;
    logic          drop_s;
    logic          hs_s;
    logic [7:0]    hdr_s;

    // Byte idx (1..9) of a stored frame record; the header is sent separately.
    function automatic logic [7:0] frame_byte(input logic [71:0] rec, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd1:    b = rec[71:64];
            4'd2:    b = rec[63:56];
            4'd3:    b = rec[55:48];
            4'd4:    b = rec[47:40];
            4'd5:    b = rec[39:32];
            4'd6:    b = rec[31:24];
            4'd7:    b = rec[23:16];
            4'd8:    b = rec[15:8];
            4'd9:    b = rec[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign record_s = {in_cyctype_dir, in_data_size, in_addr, in_data};
    assign pop_s    = (state_q == ST_IDLE) && (level_q != '0);
    assign full_s   = (level_q == LVL_FULL);
    // A pop on the same edge frees a slot, so a strobe at full is still taken.
    assign push_s   = in_clock_enable && (!full_s || pop_s);
    assign drop_s   = in_clock_enable && full_s && !pop_s;
    assign hs_s     = out_valid_q && out_ready;
    assign hdr_s    = drop_pending_q ? HDR_DROP : HDR_OK;

    // Next-state values for level, overflow counter and drop flag.
    always_comb begin
        level_d        = level_q;
        ovf_d          = ovf_q;
        drop_pending_d = drop_pending_q;

        if (push_s && !pop_s) begin
            level_d = level_q + LVL_ONE;
        end else if (pop_s && !push_s) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end

        if (drop_s && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end else begin
            ovf_d = ovf_q;
        end

        // The popped frame consumes the flag, but a drop on that very edge
        // belongs to the gap before the following frame.
        if (pop_s) begin
            drop_pending_d = drop_s;
        end else begin
            drop_pending_d = drop_pending_q | drop_s;
        end
    end

    // Record storage write port.
    always_ff @(posedge lpc_clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= record_s;
        end
    end

    // FIFO pointers, fill level, overflow counter and drop flag.
    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            ovf_q          <= 16'h0000;
            drop_pending_q <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            level_q        <= level_d;
            ovf_q          <= ovf_d;
            drop_pending_q <= drop_pending_d;
        end
    end

    // Frame FSM: pops the head record in IDLE and serialises it in SEND.
    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            idx_q       <= 4'd0;
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        frame_q     <= mem_q[rd_ptr_q];
                        idx_q       <= 4'd0;
                        out_byte_q  <= hdr_s;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SEND;
                    end else begin
                        busy_q <= (level_d != '0);
                    end
                end
                ST_SEND: begin
                    if (hs_s) begin
                        if (idx_q == 4'd9) begin
                            out_valid_q <= 1'b0;
                            out_byte_q  <= 8'h00;
                            busy_q      <= (level_d != '0);
                            state_q     <= ST_IDLE;
                        end else begin
                            idx_q      <= idx_q + 4'd1;
                            out_byte_q <= frame_byte(frame_q, idx_q + 4'd1);
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_byte       = out_byte_q;
    assign out_valid      = out_valid_q;
    assign fifo_level     = level_q;
    assign overflow_count = ovf_q;
    assign busy           = busy_q;

endmodule

// File: doc/lpc_record_scheduler.md
# lpc_record_scheduler

Buffers decoded LPC cycle records from the `lpc` sniffer decoder and schedules them onto a byte-wide valid/ready stream for the host link (UART/FT245 TX). Sits directly behind `lpc`, so decoded cycles are never lost while the byte sink stalls. Overflow is counted and flagged in-band so host software can detect gaps.

## Interface
- `FIFO_DEPTH`, 8: record FIFO depth; power of two, at least 2.
- `HDR_OK`, 8'hA5: frame header byte when no drop preceded the record.
- `HDR_DROP`, 8'hA6: frame header byte when one or more records were dropped since the previous frame.

Ports:
- `lpc_clock`  in  1  single clock for the block.
- `lpc_reset`  in  1  asynchronous, active-high reset.
- `in_cyctype_dir`  in  4  decoder cycle type/direction.
- `in_addr`  in  32  decoder address.
- `in_data`  in  32  decoder data.
- `in_data_size`  in  4  decoder data size.
- `in_clock_enable`  in  1  one-cycle strobe; record fields valid while it is high.
- `out_byte`  out  8  stream byte.
- `out_valid`  out  1  `out_byte` valid.
- `out_ready`  in  1  sink accepts the byte when both valid and ready are high at a rising edge.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  records stored.
- `overflow_count`  out  16  dropped records; saturates at 16'hFFFF.
- `busy`  out  1  high when FIFO is non-empty or the FSM is not IDLE.

## Operation
- Record width is 72 bits: {ct_dir, size, addr, data}.
- Push: happens when `in_clock_enable` is high at a rising edge. The record is accepted when level < FIFO_DEPTH, or when a pop occurs on the same edge.
- Drop: otherwise the record is dropped, `overflow_count` increments (saturating), and `drop_pending` is set.
- Frame: 10 bytes, sent in this order:
  - byte 0: header;
  - byte 1: {ct_dir[3:0], size[3:0]};
  - bytes 2-5: addr, MSB first;
  - bytes 6-9: data, MSB first.
- FSM states: IDLE, SEND.
  - IDLE: when level > 0, pop the head into a 72-bit frame register. Latch the header as HDR_DROP if `drop_pending` is set, else HDR_OK. Clear `drop_pending`, unless a drop occurs on the same edge, in which case it stays set. Set byte index to 0 and go to SEND.
  - SEND: `out_valid` is high. On each handshake, byte index increments. On the handshake of byte 9, go to IDLE.
- `out_byte` and `out_valid` are registered. They are held stable while `out_valid` is high and `out_ready` is low.
- Valid never drops mid-frame.
- `fifo_level` reflects pushes and pops; on a simultaneous push and pop, the level is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `out_valid`=0, `out_byte`=0, `fifo_level`=0, `overflow_count`=0, `busy`=0, `drop_pending`=0, FSM=IDLE, pointers=0.
- Reset mid-frame: asserting `lpc_reset` clears everything immediately (asynchronous), including `out_valid`. The partial frame and stored records are discarded and never resumed.
- Latency with the sink always ready:
  - strobe sampled at edge N;
  - `fifo_level`=1 after N;
  - pop at N+1;
  - `out_valid` high after N+1;
  - byte 9 accepted at edge N+11;
  - `out_valid` low after N+11.
- Frame-to-frame gap: at least 1 cycle with `out_valid` low between frames (IDLE pop cycle).
- Throughput with the sink always ready: 1 record per 11 cycles.
- Strobe during the pop edge: the push is accepted even when the FIFO was full before the edge.
- `overflow_count` at 16'hFFFF stays there; further drops still set `drop_pending`.

## Test plan
- Single IO read: ct_dir=0, size=1, addr=32'h7FE5, data=32'h6C, `out_ready`=1. Bytes must be A5 01 00 00 7F E5 00 00 00 6C. `out_valid` rises 2 edges after the strobe. `busy` falls after byte 9.
- Back-to-back: strobes on consecutive cycles with addr 7FE4 then 7FE5. Two frames in order, with exactly one valid-low cycle between them. No drops.
- Backpressure: `out_ready` toggled pseudo-randomly. `out_byte` must be stable across stalled cycles, and the byte sequence must be identical to the unstalled case.
- Overflow: FIFO_DEPTH=8 with `out_ready`=0 and 12 strobes.
  - While stalled: `fifo_level`=7 (1 popped into SEND); one more strobe is accepted, so level=8; `overflow_count`=3; drops occur from the 10th strobe on.
  - Release `out_ready`: the first frame header is A5. The next frame header is A6 (drop_pending set before that pop). The following headers are A5.
- Simultaneous push and pop at full: the strobe coincides with the IDLE pop edge while level=8. The record is accepted, level stays 8, and `overflow_count` does not change.
- Reset mid-frame: assert `lpc_reset` after byte 4 is accepted. `out_valid`, `fifo_level`, `overflow_count` and `busy` go to 0 immediately. After release, a new strobe produces a full frame starting with A5.
